regfile_wport_arbiter: RTL and testbench

Controls the single write port of the 32x32 CPU register file. The port is shared between two requesters. Requester A is the pipeline writeback stage, which is never backpressured. Requester B is a multicycle unit (mult/div), which uses a valid/ready handshake and is buffered in a small FIFO. The block also keeps a pending-write scoreboard for B destinations so hazard logic can stall dependent reads, and it raises a stall request when B is starved.

---
 rtl/regfile_wport_arbiter.sv | 147 ++++++++++++++
 tb/tb_regfile_wport_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wport_arbiter.sv
// Register-file write port arbiter: writeback (A) has priority, mult/div (B) drains from a FIFO one cycle after acceptance.
// B is backpressured only by FIFO full; a starved FIFO raises stall_req, and a scoreboard tracks outstanding B destinations.

module regfile_wport_arbiter_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= din;
  end
endmodule

module regfile_wport_arbiter #(
  parameter int DEPTH  = 2,
  parameter int STARVE = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        a_wen,
  input  logic [4:0]  a_wsel,
  input  logic [31:0] a_wdat,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_wsel,
  input  logic [31:0] b_wdat,
  input  logic        iss_valid,
  input  logic [4:0]  iss_wsel,
  input  logic [4:0]  chk_sel1,
  input  logic [4:0]  chk_sel2,
  output logic        hazard1,
  output logic        hazard2,
  output logic        stall_req,
  output logic        rf_wen,
  output logic [4:0]  rf_wsel,
  output logic [31:0] rf_wdat,
  output logic [31:0] pending
);
  localparam int CW = $clog2(STARVE + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE);

  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        a_own;
  logic [36:0] head;
  logic [4:0]  head_wsel;
  logic [31:0] head_wdat;
  logic [CW-1:0] starve_cnt;
  logic [31:0] pending_nxt;

  assign b_ready = !fifo_full;
  assign push    = b_valid && b_ready;
  assign a_own   = a_wen && (a_wsel != 5'd0);
  assign pop     = !fifo_empty && !a_own;

  assign head_wsel = head[36:32];
  assign head_wdat = head[31:0];

  regfile_wport_arbiter_fifo #(.W(37), .DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .nRST  (nRST),
    .push  (push),
    .pop   (pop),
    .din   ({b_wsel, b_wdat}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    rf_wen  = 1'b0;
    rf_wsel = 5'd0;
    rf_wdat = 32'd0;
    if (a_own) begin
      rf_wen  = 1'b1;
      rf_wsel = a_wsel;
      rf_wdat = a_wdat;
    end else if (pop) begin
      rf_wen  = (head_wsel != 5'd0);
      rf_wsel = head_wsel;
      rf_wdat = head_wdat;
    end
  end

  // A non-empty FIFO that does not pop is necessarily blocked by A.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= '0;
    end else if (fifo_empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign stall_req = (starve_cnt == STARVE_MAX);

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_comb begin
    pending_nxt = pending;
    if (pop && head_wsel != 5'd0)   pending_nxt[head_wsel] = 1'b0;
    if (iss_valid && iss_wsel != 5'd0) pending_nxt[iss_wsel] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) pending <= '0;
    else       pending <= pending_nxt;
  end

  assign hazard1 = pending[chk_sel1];
  assign hazard2 = pending[chk_sel2];
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter: inputs change 1ns after posedge, outputs checked at negedge.
`timescale 1ns/1ps
module tb_regfile_wport_arbiter;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        a_wen;
  logic [4:0]  a_wsel;
  logic [31:0] a_wdat;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_wsel;
  logic [31:0] b_wdat;
  logic        iss_valid;
  logic [4:0]  iss_wsel;
  logic [4:0]  chk_sel1;
  logic [4:0]  chk_sel2;
  logic        hazard1;
  logic        hazard2;
  logic        stall_req;
  logic        rf_wen;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;
  logic [31:0] pending;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  regfile_wport_arbiter #(.DEPTH(2), .STARVE(4)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .a_wen     (a_wen),
    .a_wsel    (a_wsel),
    .a_wdat    (a_wdat),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_wsel    (b_wsel),
    .b_wdat    (b_wdat),
    .iss_valid (iss_valid),
    .iss_wsel  (iss_wsel),
    .chk_sel1  (chk_sel1),
    .chk_sel2  (chk_sel2),
    .hazard1   (hazard1),
    .hazard2   (hazard2),
    .stall_req (stall_req),
    .rf_wen    (rf_wen),
    .rf_wsel   (rf_wsel),
    .rf_wdat   (rf_wdat),
    .pending   (pending)
  );

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    a_wen = 0; a_wsel = 0; a_wdat = 0;
    b_valid = 0; b_wsel = 0; b_wdat = 0;
    iss_valid = 0; iss_wsel = 0; chk_sel1 = 0; chk_sel2 = 0;
    cyc(); cyc();
    nRST = 1'b1;
    cyc();
    @(negedge CLK);
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL reset_rf_wen got %b want 0", rf_wen); end
    n_cmp++; if (rf_wsel !== 5'd0) begin n_bad++; $display("FAIL reset_rf_wsel got %0d want 0", rf_wsel); end
    n_cmp++; if (rf_wdat !== 32'd0) begin n_bad++; $display("FAIL reset_rf_wdat got %h want 0", rf_wdat); end
    n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL reset_b_ready got %b want 1", b_ready); end
    n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall_req); end
    n_cmp++; if (pending !== 32'd0) begin n_bad++; $display("FAIL reset_pending got %h want 0", pending); end
    n_cmp++; if ({hazard1, hazard2} !== 2'b00) begin n_bad++; $display("FAIL reset_hazard got %b want 00", {hazard1, hazard2}); end
  endtask

  task automatic test_issue();
    cyc();
    iss_valid = 1; iss_wsel = 5; chk_sel1 = 5; chk_sel2 = 0;
    @(negedge CLK);
    n_cmp++; if (hazard1 !== 1'b0) begin n_bad++; $display("FAIL issue_same_cycle_hazard got %b want 0", hazard1); end
    cyc();
    iss_valid = 0;
    @(negedge CLK);
    n_cmp++; if (pending !== 32'h20) begin n_bad++; $display("FAIL issue_pending got %h want 00000020", pending); end
    n_cmp++; if (hazard1 !== 1'b1) begin n_bad++; $display("FAIL issue_hazard1 got %b want 1", hazard1); end
    n_cmp++; if (hazard2 !== 1'b0) begin n_bad++; $display("FAIL issue_hazard2 got %b want 0", hazard2); end
  endtask

  task automatic test_b_result();
    cyc();
    b_valid = 1; b_wsel = 5; b_wdat = 32'hDEADBEEF;
    @(negedge CLK);
    n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL bres_ready got %b want 1", b_ready); end
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL bres_no_bypass got %b want 0", rf_wen); end
    cyc();
    b_valid = 0;
    @(negedge CLK);
    n_cmp++; if (rf_wen !== 1'b1) begin n_bad++; $display("FAIL bres_wen got %b want 1", rf_wen); end
    n_cmp++; if (rf_wsel !== 5'd5) begin n_bad++; $display("FAIL bres_wsel got %0d want 5", rf_wsel); end
    n_cmp++; if (rf_wdat !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bres_wdat got %h want deadbeef", rf_wdat); end
    n_cmp++; if (pending !== 32'h20) begin n_bad++; $display("FAIL bres_pending_held got %h want 00000020", pending); end
    cyc();
    @(negedge CLK);
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL bres_pending_clr got %h want 0", pending); end
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL bres_idle_wen got %b want 0", rf_wen); end
  endtask

  task automatic test_starve();
    cyc();
    a_wen = 1; a_wsel = 3; a_wdat = 32'h33;
    b_valid = 1; b_wsel = 10; b_wdat = 32'hA;
    @(negedge CLK);
    n_cmp++; if ({rf_wen, rf_wsel, rf_wdat} !== {1'b1, 5'd3, 32'h33}) begin n_bad++; $display("FAIL starve_a_write got %b/%0d/%h want 1/3/33", rf_wen, rf_wsel, rf_wdat); end
    cyc();
    b_wsel = 11; b_wdat = 32'hB;
    @(negedge CLK);
    n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL starve_ready_one got %b want 1", b_ready); end
    cyc();
    b_wsel = 12; b_wdat = 32'hC;
    @(negedge CLK);
    n_cmp++; if (b_ready !== 1'b0) begin n_bad++; $display("FAIL starve_full got %b want 0", b_ready); end
    cyc();
    b_valid = 0;
    @(negedge CLK);
    n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL starve_cnt2 got %b want 0", stall_req); end
    cyc();
    @(negedge CLK);
    n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL starve_cnt3 got %b want 0", stall_req); end
    cyc();
    @(negedge CLK);
    n_cmp++; if (stall_req !== 1'b1) begin n_bad++; $display("FAIL starve_cnt4 got %b want 1", stall_req); end
    n_cmp++; if (rf_wsel !== 5'd3) begin n_bad++; $display("FAIL starve_a_wins got %0d want 3", rf_wsel); end
    cyc();
    a_wen = 0;
    @(negedge CLK);
    n_cmp++; if (stall_req !== 1'b1) begin n_bad++; $display("FAIL starve_saturate got %b want 1", stall_req); end
    n_cmp++; if ({rf_wen, rf_wsel, rf_wdat} !== {1'b1, 5'd10, 32'hA}) begin n_bad++; $display("FAIL drain_first got %b/%0d/%h want 1/10/a", rf_wen, rf_wsel, rf_wdat); end
    cyc();
    @(negedge CLK);
    n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL drain_stall_clr got %b want 0", stall_req); end
    n_cmp++; if ({rf_wen, rf_wsel, rf_wdat} !== {1'b1, 5'd11, 32'hB}) begin n_bad++; $display("FAIL drain_second got %b/%0d/%h want 1/11/b", rf_wen, rf_wsel, rf_wdat); end
    cyc();
    @(negedge CLK);
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL drain_empty got %b want 0", rf_wen); end
    n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL drain_ready got %b want 1", b_ready); end
  endtask

  task automatic test_a_zero();
    cyc();
    a_wen = 1; a_wsel = 3; a_wdat = 32'h33;
    b_valid = 1; b_wsel = 9; b_wdat = 32'h99;
    cyc();
    b_valid = 0; a_wsel = 0; a_wdat = 32'h55;
    @(negedge CLK);
    n_cmp++; if ({rf_wen, rf_wsel, rf_wdat} !== {1'b1, 5'd9, 32'h99}) begin n_bad++; $display("FAIL azero_b_drains got %b/%0d/%h want 1/9/99", rf_wen, rf_wsel, rf_wdat); end
    cyc();
    a_wen = 0;
    @(negedge CLK);
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL azero_popped got %b want 0", rf_wen); end
  endtask

  task automatic test_b_zero();
    cyc();
    b_valid = 1; b_wsel = 0; b_wdat = 32'h77;
    cyc();
    b_valid = 0;
    @(negedge CLK);
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL bzero_wen got %b want 0", rf_wen); end
    n_cmp++; if (rf_wdat !== 32'h77) begin n_bad++; $display("FAIL bzero_head got %h want 77", rf_wdat); end
    cyc();
    b_valid = 1; b_wsel = 4; b_wdat = 32'h44;
    @(negedge CLK);
    n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL bzero_stall got %b want 0", stall_req); end
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL bzero_empty got %b want 0", rf_wen); end
    cyc();
    b_valid = 0;
    @(negedge CLK);
    n_cmp++; if ({rf_wen, rf_wsel, rf_wdat} !== {1'b1, 5'd4, 32'h44}) begin n_bad++; $display("FAIL bzero_next got %b/%0d/%h want 1/4/44", rf_wen, rf_wsel, rf_wdat); end
  endtask

  task automatic test_set_clear();
    cyc();
    iss_valid = 1; iss_wsel = 7;
    b_valid = 1; b_wsel = 7; b_wdat = 32'h70;
    cyc();
    b_valid = 0;
    chk_sel2 = 7;
    @(negedge CLK);
    n_cmp++; if ({rf_wen, rf_wsel} !== {1'b1, 5'd7}) begin n_bad++; $display("FAIL setclr_pop got %b/%0d want 1/7", rf_wen, rf_wsel); end
    cyc();
    iss_valid = 0;
    @(negedge CLK);
    n_cmp++; if (pending !== 32'h80) begin n_bad++; $display("FAIL setclr_pending got %h want 00000080", pending); end
    n_cmp++; if (hazard2 !== 1'b1) begin n_bad++; $display("FAIL setclr_hazard2 got %b want 1", hazard2); end
  endtask

  task automatic test_reset_mid();
    cyc();
    a_wen = 1; a_wsel = 3; a_wdat = 32'h33;
    b_valid = 1; b_wsel = 12; b_wdat = 32'hC;
    iss_valid = 1; iss_wsel = 12;
    cyc();
    b_wsel = 13; b_wdat = 32'hD; iss_wsel = 13;
    cyc();
    b_valid = 0; iss_valid = 0; a_wen = 0;
    @(negedge CLK);
    n_cmp++; if ({rf_wen, rf_wsel} !== {1'b1, 5'd12}) begin n_bad++; $display("FAIL rmid_drain got %b/%0d want 1/12", rf_wen, rf_wsel); end
    n_cmp++; if (pending !== 32'h3080) begin n_bad++; $display("FAIL rmid_pending got %h want 00003080", pending); end
    #1 nRST = 1'b0;
    #1;
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL rmid_wen got %b want 0", rf_wen); end
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL rmid_pending_clr got %h want 0", pending); end
    cyc();
    nRST = 1'b1;
    @(negedge CLK);
    n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready got %b want 1", b_ready); end
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL rmid_discard got %b want 0", rf_wen); end
    n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL rmid_stall got %b want 0", stall_req); end
  endtask

  initial begin
    test_reset();
    test_issue();
    test_b_result();
    test_starve();
    test_a_zero();
    test_b_zero();
    test_set_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
